// File: rtl/end_screen_panel.sv
// end_screen_panel: VGA overlay stage that draws a bordered, solid-filled panel which
// opens and closes with a per-frame vertical wipe. Adds one clock of latency to the bus.
// Optional feature: define ENDPANEL_BLINK_EN to blink the border while fully open.
// Bus layout (MSB..LSB): hcount[10:0], vcount[10:0], hsync, vsync, rgb[11:0].
module end_screen_panel #(
  parameter int unsigned VGA_BUS_SIZE = 36,
  parameter int unsigned XPOS         = 500,
  parameter int unsigned YPOS         = 100,
  parameter int unsigned WIDTH        = 150,
  parameter int unsigned HEIGHT       = 50,
  parameter int unsigned BORDER       = 2,
  parameter int unsigned STEP         = 4,
  parameter logic [11:0] FILL_COLOR   = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                    panel_shown,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StReveal, StShown, StHide} state_e;

  // All geometry is evaluated in 12 bits so sums of 11-bit coordinates never wrap.
  localparam logic [11:0] XLo      = 12'(XPOS);
  localparam logic [11:0] XHi      = 12'(XPOS + WIDTH);
  localparam logic [11:0] XLeftB   = 12'(XPOS + BORDER);
  localparam logic [11:0] XRightB  = 12'(XPOS + WIDTH - BORDER);
  localparam logic [11:0] YLo      = 12'(YPOS);
  localparam logic [11:0] YTopB    = 12'(YPOS + BORDER);
  localparam logic [11:0] Border12 = 12'(BORDER);
  localparam logic [11:0] Step12   = 12'(STEP);
  localparam logic [11:0] Height12 = 12'(HEIGHT);

  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in;
  logic [11:0] rgb_in;

  assign {hcount_in, vcount_in, hsync_in, vsync_in, rgb_in} = vga_bus_in;

  state_e      state_q, state_d;
  logic [10:0] vis_h_q, vis_h_d;
  logic        tick;
  logic [11:0] vis12, inc12, dec12, sum12;

  assign tick  = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign vis12 = {1'b0, vis_h_q};
  assign sum12 = vis12 + Step12;
  assign inc12 = (sum12 > Height12) ? Height12 : sum12;
  assign dec12 = (vis12 >= Step12) ? (vis12 - Step12) : 12'd0;

  // Next state: every tick moves vis_h one STEP toward the requested end (open or closed),
  // so a reversal mid-wipe continues smoothly from the current height.
  always_comb begin
    state_d = state_q;
    vis_h_d = vis_h_q;
    if (tick) begin
      if (module_en) begin
        vis_h_d = inc12[10:0];
        state_d = (inc12 == Height12) ? StShown : StReveal;
      end else begin
        vis_h_d = dec12[10:0];
        state_d = (dec12 == 12'd0) ? StIdle : StHide;
      end
    end
  end

  // State, visible height and the decoded status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      vis_h_q     <= 11'd0;
      panel_shown <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vis_h_q     <= vis_h_d;
      panel_shown <= (state_d == StShown);
      busy        <= (state_d == StReveal) || (state_d == StHide);
    end
  end

  logic [11:0] border_rgb;

`ifdef ENDPANEL_BLINK_EN
  localparam logic [15:0] BlinkLast = 16'(BLINK_FRAMES - 1);

  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;

  // Blink phase advances once per frame, only while the panel stays fully open.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (tick) begin
      if ((state_q == StShown) && (state_d == StShown)) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_d = 16'd0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end else begin
        blink_cnt_d = 16'd0;
        blink_d     = 1'b0;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= 16'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign border_rgb = blink_q ? FILL_COLOR : BORDER_COLOR;
`else
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
  assign border_rgb          = BORDER_COLOR;
`endif

  logic [11:0] h12, v12, y_bot;
  logic        in_panel, on_border;
  logic [11:0] rgb_out_nxt;

  assign h12   = {1'b0, hcount_in};
  assign v12   = {1'b0, vcount_in};
  assign y_bot = YLo + vis12;

  // Pixel classification against the current (wipe-limited) panel rectangle.
  always_comb begin
    in_panel    = (h12 >= XLo) && (h12 < XHi) && (v12 >= YLo) && (v12 < y_bot);
    // Bottom test written as v + BORDER >= bottom to avoid underflow when vis_h < BORDER.
    on_border   = (h12 < XLeftB) || (h12 >= XRightB) || (v12 < YTopB) ||
                  ((v12 + Border12) >= y_bot);
    rgb_out_nxt = rgb_in;
    if (in_panel) begin
      rgb_out_nxt = on_border ? border_rgb : FILL_COLOR;
    end
  end

  // Output bus register: timing fields delayed unchanged, rgb replaced inside the panel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_bus_out <= '0;
    end else begin
      vga_bus_out <= {hcount_in, vcount_in, hsync_in, vsync_in, rgb_out_nxt};
    end
  end

endmodule
